// File: rtl/mem_stage_p.sv
// mem_stage_p
// Memory-access pipeline stage between EX and WB of the in-order CPU.
// It registers the EX result under the shared stall vector. A small FSM
// tracks the outstanding load, and a load buffer keeps the response once
// it has arrived. Sub-word load data is extracted by byte lane and then
// sign- or zero-extended. The stage drives the WB bus and the ID
// forwarding bus.
//
// Ports
//   clk                : clock, rising edge
//   rst                : asynchronous reset, active-low
//   stall              : pipeline stall vector (1 = stop). Bit ST_IDX is
//                        this stage; bit ST_IDX+1 is the downstream stage.
//   ex_valid .. ex_ld_unsigned : instruction fields from EX
//   data_sram_rdata    : load response data
//   data_sram_rvalid   : load response valid, one cycle per request
//   stallreq_mem       : stall request for this and earlier stages
//   wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata : bus to WB
//   fwd_rf_we, fwd_rf_waddr, fwd_rf_wdata : forwarding bus to ID
//   fwd_load_pending   : forwarded data not yet valid (load still waiting)
module mem_stage_p #(
  parameter int DW      = 32,
  parameter int PCW     = 32,
  parameter int RAW     = 5,
  parameter int STALL_W = 6,
  parameter int ST_IDX  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [PCW-1:0]     ex_pc,
  input  logic               ex_rf_we,
  input  logic [RAW-1:0]     ex_rf_waddr,
  input  logic [DW-1:0]      ex_result,
  input  logic               ex_load,
  input  logic [1:0]         ex_ld_size,
  input  logic               ex_ld_unsigned,
  input  logic [DW-1:0]      data_sram_rdata,
  input  logic               data_sram_rvalid,
  output logic               stallreq_mem,
  output logic               wb_valid,
  output logic [PCW-1:0]     wb_pc,
  output logic               wb_rf_we,
  output logic [RAW-1:0]     wb_rf_waddr,
  output logic [DW-1:0]      wb_rf_wdata,
  output logic               fwd_rf_we,
  output logic [RAW-1:0]     fwd_rf_waddr,
  output logic [DW-1:0]      fwd_rf_wdata,
  output logic               fwd_load_pending
);

  localparam int OB = $clog2(DW / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } ld_state_t;

  // Byte-lane extraction: align the offset down to the access size, shift the
  // selected lane to bit 0, then sign- or zero-extend. A dword request on a
  // 32-bit datapath degrades to a word access.
  function automatic logic [DW-1:0] ld_extract(
    input logic [DW-1:0] src,
    input logic [OB-1:0] off,
    input logic [1:0]    size,
    input logic          uns
  );
    logic [1:0]    sz;
    logic [OB-1:0] amask;
    logic [OB-1:0] aoff;
    logic [DW-1:0] sh;
    logic [DW-1:0] keep;
    logic          sgn;
    sz = size;
    if (DW == 32 && size == 2'd3) sz = 2'd2;
    case (sz)
      2'd0:    amask = '0;
      2'd1:    amask = OB'(1);
      2'd2:    amask = OB'(3);
      default: amask = OB'(7);
    endcase
    aoff = off & ~amask;
    sh   = src >> {aoff, 3'b000};
    case (sz)
      2'd0: begin
        keep = DW'(64'h0000_0000_0000_00FF);
        sgn  = sh[7];
      end
      2'd1: begin
        keep = DW'(64'h0000_0000_0000_FFFF);
        sgn  = sh[15];
      end
      2'd2: begin
        keep = DW'(64'h0000_0000_FFFF_FFFF);
        sgn  = sh[31];
      end
      default: begin
        keep = '1;
        sgn  = sh[DW-1];
      end
    endcase
    sgn = sgn & ~uns;
    return (sh & keep) | (~keep & {DW{sgn}});
  endfunction

  logic r_stall;
  logic r_down_stall;
  logic r_bubble;
  logic r_adv;
  logic r_hold;
  logic unused_stall;

  assign r_stall      = stall[ST_IDX];
  assign r_down_stall = stall[ST_IDX+1];
  assign r_bubble     = r_stall & ~r_down_stall;
  assign r_adv        = ~r_stall;
  assign r_hold       = r_stall & r_down_stall;
  assign unused_stall = ^stall;

  // ---- stage boundary: EX -> MEM pipeline register ----
  logic           vld_p1;
  logic [PCW-1:0] pc_p1;
  logic           rf_we_p1;
  logic [RAW-1:0] waddr_p1;
  logic [DW-1:0]  result_p1;
  logic           load_p1;
  logic [1:0]     ld_size_p1;
  logic           ld_uns_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rf_we_p1   <= 1'b0;
      waddr_p1   <= '0;
      result_p1  <= '0;
      load_p1    <= 1'b0;
      ld_size_p1 <= 2'd0;
      ld_uns_p1  <= 1'b0;
    end else if (r_bubble) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rf_we_p1   <= 1'b0;
      waddr_p1   <= '0;
      result_p1  <= '0;
      load_p1    <= 1'b0;
      ld_size_p1 <= 2'd0;
      ld_uns_p1  <= 1'b0;
    end else if (r_adv) begin
      vld_p1     <= ex_valid;
      pc_p1      <= ex_pc;
      rf_we_p1   <= ex_rf_we;
      waddr_p1   <= ex_rf_waddr;
      result_p1  <= ex_result;
      load_p1    <= ex_load;
      ld_size_p1 <= ex_ld_size;
      ld_uns_p1  <= ex_ld_unsigned;
    end
  end

  // Load FSM. WAIT means the load in the register has no data yet; the
  // response may arrive in the very first MEM cycle, so WAIT is entered
  // directly when a valid load is registered, and a response in that cycle
  // is consumed combinationally. DONE means the data is held in lb_q while
  // the register is held.
  ld_state_t     state_q;
  ld_state_t     state_d;
  logic          lb_cap;
  logic          ld_pend;
  logic [DW-1:0] lb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lb_cap  = 1'b0;
    ld_pend = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        ld_pend = vld_p1 & load_p1 & ~data_sram_rvalid;
        if (data_sram_rvalid && r_hold) begin
          state_d = S_DONE;
          lb_cap  = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // Register movement overrides everything: a bubble drops the load (and
    // any response arriving with it); an advance starts tracking the next.
    if (r_bubble) begin
      state_d = S_IDLE;
      lb_cap  = 1'b0;
    end else if (r_adv) begin
      state_d = (ex_valid && ex_load) ? S_WAIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lb_q <= '0;
    else if (lb_cap) lb_q <= data_sram_rdata;
  end

  // ---- stage boundary: MEM -> WB / forwarding outputs ----
  logic [DW-1:0] ld_src;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] wdata;

  assign ld_src  = (state_q == S_DONE) ? lb_q : data_sram_rdata;
  assign ld_data = ld_extract(ld_src, result_p1[OB-1:0], ld_size_p1, ld_uns_p1);
  assign wdata   = load_p1 ? ld_data : result_p1;

  assign stallreq_mem     = ld_pend;
  assign fwd_load_pending = ld_pend;
  assign wb_valid         = vld_p1 & ~ld_pend;
  assign wb_pc            = pc_p1;
  assign wb_rf_we         = rf_we_p1;
  assign wb_rf_waddr      = waddr_p1;
  assign wb_rf_wdata      = wdata;
  assign fwd_rf_we        = rf_we_p1;
  assign fwd_rf_waddr     = waddr_p1;
  assign fwd_rf_wdata     = wdata;

endmodule

// File: tb/tb_mem_stage_p.sv
module tb_mem_stage_p;

  localparam int DW  = 32;
  localparam int PCW = 32;
  localparam int RAW = 5;
  localparam int SW  = 6;
  localparam int STI = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [SW-1:0]  stall;
  logic           ex_valid;
  logic [PCW-1:0] ex_pc;
  logic           ex_rf_we;
  logic [RAW-1:0] ex_rf_waddr;
  logic [31:0]    ex_result;
  logic           ex_load;
  logic [1:0]     ex_ld_size;
  logic           ex_ld_unsigned;
  logic [31:0]    rdata;
  logic           rvalid;

  logic           stallreq;
  logic           wb_valid;
  logic [PCW-1:0] wb_pc;
  logic           wb_we;
  logic [RAW-1:0] wb_waddr;
  logic [31:0]    wb_wdata;
  logic           fwd_we;
  logic [RAW-1:0] fwd_waddr;
  logic [31:0]    fwd_wdata;
  logic           fwd_pend;

  logic [63:0]    ex_result64;
  logic [63:0]    rdata64;
  logic           stallreq64;
  logic           wb_valid64;
  logic [PCW-1:0] wb_pc64;
  logic           wb_we64;
  logic [RAW-1:0] wb_waddr64;
  logic [63:0]    wb_wdata64;
  logic           fwd_we64;
  logic [RAW-1:0] fwd_waddr64;
  logic [63:0]    fwd_wdata64;
  logic           fwd_pend64;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_p #(.DW(DW), .PCW(PCW), .RAW(RAW), .STALL_W(SW), .ST_IDX(STI)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result), .ex_load(ex_load),
    .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .data_sram_rdata(rdata), .data_sram_rvalid(rvalid),
    .stallreq_mem(stallreq), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_we(wb_we), .wb_rf_waddr(wb_waddr), .wb_rf_wdata(wb_wdata),
    .fwd_rf_we(fwd_we), .fwd_rf_waddr(fwd_waddr), .fwd_rf_wdata(fwd_wdata),
    .fwd_load_pending(fwd_pend)
  );

  mem_stage_p #(.DW(64), .PCW(PCW), .RAW(RAW), .STALL_W(SW), .ST_IDX(STI)) dut64 (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result64), .ex_load(ex_load),
    .ex_ld_size(ex_ld_size), .ex_ld_unsigned(ex_ld_unsigned),
    .data_sram_rdata(rdata64), .data_sram_rvalid(rvalid),
    .stallreq_mem(stallreq64), .wb_valid(wb_valid64), .wb_pc(wb_pc64),
    .wb_rf_we(wb_we64), .wb_rf_waddr(wb_waddr64), .wb_rf_wdata(wb_wdata64),
    .fwd_rf_we(fwd_we64), .fwd_rf_waddr(fwd_waddr64), .fwd_rf_wdata(fwd_wdata64),
    .fwd_load_pending(fwd_pend64)
  );

  typedef struct {
    logic [31:0] res;
    logic [1:0]  sz;
    bit          un;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] res;
    bit          ld;
    logic [1:0]  sz;
    bit          un;
  } mr_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load value from the architectural rule: aligned lane, then extend.
  function automatic logic [63:0] ref_ld(input logic [63:0] d, input int dw,
                                         input logic [63:0] addr, input int size,
                                         input bit uns);
    int nb;
    int off;
    logic [63:0] v;
    logic [63:0] lim;
    nb = 1 << size;
    if (nb > dw / 8) nb = dw / 8;
    off = int'(addr % 64'(dw / 8));
    off = off - (off % nb);
    v = d >> (8 * off);
    if (nb < 8) begin
      lim = 64'd1 << (8 * nb);
      v = v % lim;
      if (!uns && v >= lim / 2) v = v - lim;
    end
    if (dw < 64) v = v % (64'd1 << dw);
    return v;
  endfunction

  task automatic clr_in();
    ex_valid = 0; ex_pc = 0; ex_rf_we = 0; ex_rf_waddr = 0; ex_result = 0;
    ex_load = 0; ex_ld_size = 0; ex_ld_unsigned = 0; rvalid = 0; rdata = 0;
    stall = 0; ex_result64 = 0; rdata64 = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input bit we, input logic [4:0] wa,
                       input logic [31:0] res, input bit ld, input logic [1:0] sz,
                       input bit un);
    ex_valid = 1; ex_pc = pc; ex_rf_we = we; ex_rf_waddr = wa; ex_result = res;
    ex_load = ld; ex_ld_size = sz; ex_ld_unsigned = un;
  endtask

  task automatic set_stall(input bit lo, input bit hi);
    stall = '0;
    stall[STI] = lo;
    stall[STI+1] = hi;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stallreq"}, stallreq, 0);
    chk({tag, "_pend"}, fwd_pend, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_wb_waddr"}, wb_waddr, 0);
    chk({tag, "_wb_wdata"}, wb_wdata, 0);
    chk({tag, "_wb_pc"}, wb_pc, 0);
    chk({tag, "_fwd_wdata"}, fwd_wdata, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[10];
    mr_t m;
    bit m_done;
    logic [31:0] m_lb;
    vec[0] = '{32'h3, 2'd0, 1'b0, 32'h80FFFFFF, 32'hFFFFFF80};
    vec[1] = '{32'h3, 2'd0, 1'b1, 32'h80FFFFFF, 32'h00000080};
    vec[2] = '{32'h1, 2'd0, 1'b0, 32'h12347F56, 32'h0000007F};
    vec[3] = '{32'h2, 2'd1, 1'b0, 32'h80010000, 32'hFFFF8001};
    vec[4] = '{32'h3, 2'd1, 1'b1, 32'h80010000, 32'h00008001};
    vec[5] = '{32'h1, 2'd1, 1'b0, 32'h0000F00F, 32'hFFFFF00F};
    vec[6] = '{32'h6, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[7] = '{32'h4, 2'd3, 1'b0, 32'h01234567, 32'h01234567};
    vec[8] = '{32'h0, 2'd0, 1'b0, 32'h000000FF, 32'hFFFFFFFF};
    vec[9] = '{32'h2, 2'd0, 1'b1, 32'h00AB0000, 32'h000000AB};

    clr_in();
    rst = 0;
    @(negedge clk);
    #1 chk_zero("reset");
    rst = 1;

    // Plain ALU result through the stage
    issue(32'h100, 1, 5'd7, 32'h12345678, 0, 2'd0, 0);
    cyc();
    ex_valid = 0;
    #1;
    chk("nl_wdata", wb_wdata, 32'h12345678);
    chk("nl_waddr", wb_waddr, 7);
    chk("nl_valid", wb_valid, 1);
    chk("nl_stallreq", stallreq, 0);
    chk("nl_pc", wb_pc, 32'h100);
    chk("nl_fwd_we", fwd_we, 1);
    chk("nl_fwd_wdata", fwd_wdata, 32'h12345678);

    // Zero-wait loads of every size and lane
    for (int i = 0; i < 10; i++) begin
      issue(32'h200 + 32'(i * 4), 1, 5'(i + 1), vec[i].res, 1, vec[i].sz, vec[i].un);
      rvalid = 0;
      cyc();
      ex_valid = 0; rvalid = 1; rdata = vec[i].rd;
      #1;
      chk($sformatf("vec%0d_wdata", i), wb_wdata, vec[i].exp);
      chk($sformatf("vec%0d_valid", i), wb_valid, 1);
      chk($sformatf("vec%0d_stallreq", i), stallreq, 0);
    end
    rvalid = 0;
    cyc();

    // Halfword load answered three cycles late
    issue(32'h300, 1, 5'd3, 32'h1002, 1, 2'd1, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      ex_valid = 0; set_stall(1, 1); rvalid = 0; rdata = $urandom;
      #1;
      chk($sformatf("late%0d_stallreq", k), stallreq, 1);
      chk($sformatf("late%0d_pend", k), fwd_pend, 1);
      chk($sformatf("late%0d_valid", k), wb_valid, 0);
      cyc();
    end
    rvalid = 1; rdata = 32'h7FFF0000; set_stall(0, 0);
    #1;
    chk("late_resp_valid", wb_valid, 1);
    chk("late_resp_wdata", wb_wdata, 32'h00007FFF);
    chk("late_resp_stallreq", stallreq, 0);
    chk("late_resp_pend", fwd_pend, 0);
    chk("late_resp_waddr", wb_waddr, 3);
    rvalid = 0;
    cyc();
    #1 chk("late_after_stallreq", stallreq, 0);

    // Load completes while downstream is stalled; later rdata is garbage
    issue(32'h400, 1, 5'd4, 32'h2000, 1, 2'd2, 0);
    cyc();
    ex_valid = 0; set_stall(1, 1); rvalid = 1; rdata = 32'hCAFEBABE;
    #1;
    chk("lb_first_wdata", wb_wdata, 32'hCAFEBABE);
    chk("lb_first_stallreq", stallreq, 0);
    chk("lb_first_valid", wb_valid, 1);
    cyc();
    rvalid = 0; rdata = 32'hDEADDEAD;
    #1;
    chk("lb_hold1_wdata", wb_wdata, 32'hCAFEBABE);
    chk("lb_hold1_stallreq", stallreq, 0);
    chk("lb_hold1_pend", fwd_pend, 0);
    cyc();
    rvalid = 1; rdata = 32'h11111111;
    #1;
    chk("lb_hold2_wdata", wb_wdata, 32'hCAFEBABE);
    chk("lb_hold2_stallreq", stallreq, 0);
    set_stall(0, 0); rvalid = 0;
    cyc();
    #1 chk("lb_after_valid", wb_valid, 0);

    // Hold with both stall bits, then bubble
    issue(32'h500, 1, 5'd9, 32'hAAAA5555, 0, 2'd0, 0);
    cyc();
    set_stall(1, 1);
    issue(32'h600, 1, 5'd10, 32'h1111, 0, 2'd0, 0);
    cyc();
    #1;
    chk("hold_wdata", wb_wdata, 32'hAAAA5555);
    chk("hold_waddr", wb_waddr, 9);
    chk("hold_pc", wb_pc, 32'h500);
    chk("hold_valid", wb_valid, 1);
    set_stall(1, 0);
    cyc();
    #1 chk_zero("bubble");
    set_stall(0, 0); ex_valid = 0;

    // Asynchronous reset in the middle of a wait, then a stray response
    issue(32'h700, 1, 5'd11, 32'h3000, 1, 2'd2, 0);
    cyc();
    ex_valid = 0; set_stall(1, 1); rvalid = 0;
    #1 chk("rstw_stallreq", stallreq, 1);
    #2 rst = 0;
    #1 chk_zero("rst_async");
    cyc();
    rst = 1; rvalid = 1; rdata = 32'hFFFFFFFF;
    #1 chk_zero("rst_stray");
    cyc();
    rvalid = 0;
    #1 chk_zero("rst_after");
    set_stall(0, 0);

    // 64-bit datapath
    issue(32'h800, 1, 5'd12, 32'h0, 1, 2'd3, 0);
    ex_result64 = 64'h8;
    cyc();
    ex_valid = 0; rvalid = 1; rdata64 = 64'h8123_4567_89AB_CDEF;
    #1;
    chk("d64_ld_wdata", wb_wdata64, 64'h8123_4567_89AB_CDEF);
    chk("d64_ld_valid", wb_valid64, 1);
    chk("d64_ld_stallreq", stallreq64, 0);
    issue(32'h810, 1, 5'd13, 32'h0, 1, 2'd2, 0);
    ex_result64 = 64'h4; rvalid = 0;
    cyc();
    ex_valid = 0; rvalid = 1; rdata64 = 64'h8000_0000_1234_5678;
    #1 chk("d64_lw_wdata", wb_wdata64, 64'hFFFF_FFFF_8000_0000);
    issue(32'h820, 1, 5'd14, 32'h0, 1, 2'd0, 1);
    ex_result64 = 64'hF; rvalid = 0;
    cyc();
    ex_valid = 0; rvalid = 1; rdata64 = 64'hAB00_0000_0000_00FF;
    #1 chk("d64_lbu_wdata", wb_wdata64, 64'h0000_0000_0000_00AB);
    rvalid = 0;
    cyc();

    // Randomized traffic against the architectural model
    clr_in();
    rst = 0;
    #1 rst = 1;
    m = '{default: 0};
    m_done = 0;
    m_lb = 0;
    for (int c = 0; c < 600; c++) begin
      bit rv, lo, hi, outst, exp_sr;
      logic [31:0] rd, src, exp_wd;
      rv = ($urandom % 3) == 0;
      rd = $urandom;
      outst = m.v && m.ld && !m_done;
      exp_sr = outst && !rv;
      src = m_done ? m_lb : rd;
      exp_wd = m.ld ? 32'(ref_ld({32'h0, src}, 32, {32'h0, m.res}, int'(m.sz), m.un)) : m.res;
      if (exp_sr) begin
        lo = 1; hi = 1;
      end else begin
        lo = ($urandom % 4) == 0;
        hi = ($urandom % 3) == 0;
      end
      stall = SW'($urandom);
      stall[STI] = lo;
      stall[STI+1] = hi;
      rvalid = rv; rdata = rd;
      ex_valid = ($urandom % 4) != 0;
      ex_pc = $urandom; ex_rf_we = $urandom % 2; ex_rf_waddr = 5'($urandom);
      ex_result = $urandom; ex_load = $urandom % 2; ex_ld_size = 2'($urandom);
      ex_ld_unsigned = $urandom % 2;
      #1;
      chk($sformatf("rnd%0d_stallreq", c), stallreq, exp_sr);
      chk($sformatf("rnd%0d_pend", c), fwd_pend, exp_sr);
      chk($sformatf("rnd%0d_valid", c), wb_valid, m.v && !exp_sr);
      chk($sformatf("rnd%0d_waddr", c), fwd_waddr, m.wa);
      chk($sformatf("rnd%0d_pc", c), wb_pc, m.pc);
      chk($sformatf("rnd%0d_we", c), wb_we, m.we);
      if (!exp_sr) begin
        chk($sformatf("rnd%0d_wdata", c), wb_wdata, exp_wd);
        chk($sformatf("rnd%0d_fwd_wdata", c), fwd_wdata, exp_wd);
      end
      @(posedge clk);
      if (lo && !hi) begin
        m = '{default: 0};
        m_done = 0;
      end else if (!lo) begin
        m = '{ex_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_load,
              ex_ld_size, ex_ld_unsigned};
        m_done = 0;
      end else if (outst && rv) begin
        m_done = 1;
        m_lb = rd;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
